// File: rtl/serial_receive_work.sv
// -----------------------------------------------------------------------------
// serial_receive_work
//
// UART (8N1, LSB first) receiver that assembles a complete getwork frame of
// WORK_BYTES bytes from the host serial line. Each valid byte is shifted into
// a shadow buffer; only when the last byte of a frame has been received is the
// whole buffer copied to `data`, so the hashing core never sees a partial frame.
// The first byte of a frame ends up in data[WORK_BYTES*8-1 -: 8].
//
// Optional feature (compile-time macro RX_TIMEOUT_EN):
//   When defined, a partial frame is discarded after TIMEOUT_BAUDS bit periods
//   of idle line between bytes. When undefined, partial frames persist.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   RxD        in   serial line, idles high, asynchronous to clk
//   data       out  last complete getwork (WORK_BYTES*8 bits)
//   rx_done    out  one-cycle pulse when `data` is updated
//   frame_err  out  one-cycle pulse on a bad (low) stop bit
//   busy       out  high while a byte is in flight or a frame is partial
//
// comm_clk_frequency / baud_rate must be at least 4; WORK_BYTES at least 2.
// -----------------------------------------------------------------------------
module serial_receive_work #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200,
    parameter int WORK_BYTES         = 84,
    parameter int TIMEOUT_BAUDS      = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RxD,
    output logic [WORK_BYTES*8-1:0] data,
    output logic                    rx_done,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int BAUD_DIV = comm_clk_frequency / baud_rate;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BC_W     = $clog2(WORK_BYTES + 1);
    localparam int FW       = WORK_BYTES * 8;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BC_W-1:0]  BC_ZERO    = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]  BC_ONE     = BC_W'(1);
    localparam logic [BC_W-1:0]  LAST_COUNT = BC_W'(WORK_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_prev_r;
    logic             start_edge_s;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_next_s;
    logic [7:0]       byte_r;
    logic [7:0]       byte_next_s;
    logic             stop_ok_s;
    logic             stop_bad_s;

    logic [FW-1:0]    shadow_r;
    logic [BC_W-1:0]  byte_count_r;
    logic [BC_W-1:0]  byte_count_next_s;
    logic             frame_done_s;
    logic             timeout_s;

    // Two-flop synchroniser on RxD plus a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= RxD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    assign start_edge_s = rxd_prev_r & ~rxd_sync_r;

    // Byte count reaching WORK_BYTES is held for exactly one cycle, then publishes.
    assign frame_done_s = (byte_count_r == LAST_COUNT);

`ifdef RX_TIMEOUT_EN
    localparam int              TO_CYC  = TIMEOUT_BAUDS * BAUD_DIV;
    localparam int              TO_W    = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic            idle_cnt_r;
    logic [TO_W-1:0] idle_cycles_r;
    logic            idle_run_s;

    // The idle counter only runs between bytes of a partial frame.
    assign idle_run_s = (state_r == ST_IDLE) && (byte_count_r != BC_ZERO) &&
                        !start_edge_s && !frame_done_s;
    assign timeout_s  = idle_run_s && (idle_cycles_r == TO_LAST);

    // Counts idle cycles of a partial frame; restarts whenever the run condition drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cycles_r <= TO_ZERO;
            idle_cnt_r    <= 1'b0;
        end else if (idle_run_s && !timeout_s) begin
            idle_cycles_r <= idle_cycles_r + TO_ONE;
            idle_cnt_r    <= 1'b1;
        end else begin
            idle_cycles_r <= TO_ZERO;
            idle_cnt_r    <= 1'b0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Receiver FSM next-state: half-bit start qualification, then one sample per bit period.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        bit_idx_next_s = bit_idx_r;
        byte_next_s    = byte_r;
        stop_ok_s      = 1'b0;
        stop_bad_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    cnt_next_s   = HALF_LOAD;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_ZERO) begin
                    if (rxd_sync_r == 1'b0) begin
                        cnt_next_s     = FULL_LOAD;
                        bit_idx_next_s = 3'd0;
                        state_next_s   = ST_DATA;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_ZERO) begin
                    byte_next_s[bit_idx_r] = rxd_sync_r;
                    cnt_next_s             = FULL_LOAD;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_IDLE;
                    if (rxd_sync_r == 1'b1) begin
                        stop_ok_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame byte counter: publish clears it, a bad stop or a timeout abandons the frame.
    always_comb begin
        byte_count_next_s = byte_count_r;
        if (frame_done_s) begin
            byte_count_next_s = BC_ZERO;
        end else if (stop_ok_s) begin
            byte_count_next_s = byte_count_r + BC_ONE;
        end else if (stop_bad_s || timeout_s) begin
            byte_count_next_s = BC_ZERO;
        end else begin
            byte_count_next_s = byte_count_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            bit_idx_r    <= 3'd0;
            byte_r       <= 8'h00;
            shadow_r     <= {FW{1'b0}};
            byte_count_r <= BC_ZERO;
            data         <= {FW{1'b0}};
            rx_done      <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            bit_idx_r    <= bit_idx_next_s;
            byte_r       <= byte_next_s;
            byte_count_r <= byte_count_next_s;
            if (stop_ok_s) begin
                shadow_r <= {shadow_r[FW-9:0], byte_r};
            end
            if (frame_done_s) begin
                data <= shadow_r;
            end
            rx_done   <= frame_done_s;
            frame_err <= stop_bad_s;
            busy      <= (state_next_s != ST_IDLE) || (byte_count_next_s != BC_ZERO);
        end
    end

endmodule
